// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder block.
//   state_e    controller FSM states (IDLE, RUN, DONE)
//   MAX_WIDTH  largest supported operand width
//   cnt_width  bit-counter width for a given operand width (at least 1)
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned MAX_WIDTH = 32;

    // $clog2(1) is 0, so a 1-bit operand still gets a 1-bit counter.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle between the arithmetic front end and the serial adder.
//   start_in             add request, ignored while busy_out=1
//   a_in, b_in           operands, captured on an accepted start
//   busy_out, done_out   RUN indicator and one-cycle completion pulse
//   sum_out, carry_out   registered result, held between operations
// master: front end side; slave: serial_add_ctrl side.
interface serial_add_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start_in;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy_out;
    logic             done_out;
    logic [WIDTH-1:0] sum_out;
    logic             carry_out;

    modport master (
        output start_in, a_in, b_in,
        input  busy_out, done_out, sum_out, carry_out
    );

    modport slave (
        input  start_in, a_in, b_in,
        output busy_out, done_out, sum_out, carry_out
    );
endinterface

// File: rtl/half_adder.sv
// Combinational 1-bit half adder.
//   a_in, b_in  addend bits
//   sum_out     a ^ b
//   carry_out   a & b
module half_adder (
    input  logic a_in,
    input  logic b_in,
    output logic sum_out,
    output logic carry_out
);
    assign sum_out   = a_in ^ b_in;
    assign carry_out = a_in & b_in;
endmodule

// File: rtl/serial_fa_cell.sv
// Combinational 1-bit full adder built from two half adders and an OR.
// This cell is the only arithmetic in the serial adder.
//   a_in, b_in, c_in  addend bits and carry in
//   sum_out           a ^ b ^ c
//   carry_out         (a & b) | (c & (a ^ b))
module serial_fa_cell (
    input  logic a_in,
    input  logic b_in,
    input  logic c_in,
    output logic sum_out,
    output logic carry_out
);
    logic p;
    logic g_ab;
    logic g_pc;

    half_adder u_ha_ab (
        .a_in      (a_in),
        .b_in      (b_in),
        .sum_out   (p),
        .carry_out (g_ab)
    );

    half_adder u_ha_pc (
        .a_in      (p),
        .b_in      (c_in),
        .sum_out   (sum_out),
        .carry_out (g_pc)
    );

    assign carry_out = g_ab | g_pc;
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands LSB first, one bit per
// clock, through a single shared full-adder cell with a registered carry.
//   clk_in    rising-edge clock
//   rst_n_in  asynchronous active-low reset; aborts any operation in flight
//   bus       slave side of serial_add_ctrl_if (start/operands in, status/result out)
// Latency start edge -> done pulse is WIDTH edges; a start seen in DONE chains the
// next operation directly.
module serial_add_ctrl
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    serial_add_ctrl_if.slave bus
);
    localparam int unsigned CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             carry_q, carry_d;

    logic             s;
    logic             co;
    logic [WIDTH-1:0] sum_nxt;

    serial_fa_cell u_cell (
        .a_in      (a_sr_q[0]),
        .b_in      (b_sr_q[0]),
        .c_in      (c_q),
        .sum_out   (s),
        .carry_out (co)
    );

    // New sum bit enters at the MSB; written with shifts so WIDTH=1 needs no special case.
    assign sum_nxt = (sum_sr_q >> 1) | (WIDTH'(s) << (WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        c_d      = c_q;
        carry_d  = carry_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start_in) begin
                    a_sr_d   = bus.a_in;
                    b_sr_d   = bus.b_in;
                    sum_sr_d = '0;
                    cnt_d    = '0;
                    c_d      = 1'b0;
                    state_d  = RUN;
                end else begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                c_d      = co;
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                sum_sr_d = sum_nxt;
                if (cnt_q == LAST_BIT) begin
                    // Counter holds at the last bit so it never wraps.
                    sum_d   = sum_nxt;
                    carry_d = co;
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            sum_q    <= '0;
            cnt_q    <= '0;
            c_q      <= 1'b0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            sum_q    <= sum_d;
            cnt_q    <= cnt_d;
            c_q      <= c_d;
            carry_q  <= carry_d;
        end
    end

    // Status is decoded from the state register only, so it stays registered.
    assign bus.busy_out  = (state_q == RUN);
    assign bus.done_out  = (state_q == DONE);
    assign bus.sum_out   = sum_q;
    assign bus.carry_out = carry_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8 and WIDTH=1 instances).
// Expected results come from plain a+b arithmetic and the documented timing.
module tb_serial_add_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    serial_add_ctrl_if #(.WIDTH(8)) bus8 ();
    serial_add_ctrl_if #(.WIDTH(1)) bus1 ();

    serial_add_ctrl #(.WIDTH(8)) u_dut8 (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus8.slave)
    );

    serial_add_ctrl #(.WIDTH(1)) u_dut1 (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus1.slave)
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Last result the bench expects each DUT to be holding.
    logic [7:0] last_sum8 = '0;
    logic       last_c8   = 1'b0;
    logic       last_sum1 = 1'b0;
    logic       last_c1   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One WIDTH=8 operation from IDLE. With noisy=1, extra start pulses carrying
    // other operands are driven in RUN cycles 3 and 5; they must be ignored.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit noisy);
        logic [8:0] exp;
        int         lat;
        int         busy_n;
        logic       held;
        exp = {1'b0, a} + {1'b0, b};
        @(negedge clk);
        bus8.start_in = 1'b1;
        bus8.a_in     = a;
        bus8.b_in     = b;
        @(negedge clk);
        bus8.start_in = 1'b0;
        lat    = 0;
        busy_n = 0;
        held   = 1'b1;
        while (!bus8.done_out && lat < 40) begin
            bus8.a_in     = 8'($urandom);
            bus8.b_in     = 8'($urandom);
            bus8.start_in = noisy && (lat == 2 || lat == 4);
            if (bus8.busy_out) busy_n++;
            if (bus8.sum_out !== last_sum8 || bus8.carry_out !== last_c8) held = 1'b0;
            @(negedge clk);
            lat++;
        end
        bus8.start_in = 1'b0;
        check("lat8", lat, 8);
        check("busy8_cycles", busy_n, 8);
        check("hold8", held, 1'b1);
        check("sum8", bus8.sum_out, exp[7:0]);
        check("carry8", bus8.carry_out, exp[8]);
        last_sum8 = exp[7:0];
        last_c8   = exp[8];
        @(negedge clk);
        check("done8_single", bus8.done_out, 1'b0);
    endtask

    task automatic op1(input logic a, input logic b);
        logic [1:0] exp;
        int         lat;
        logic       held;
        exp = {1'b0, a} + {1'b0, b};
        @(negedge clk);
        bus1.start_in = 1'b1;
        bus1.a_in     = a;
        bus1.b_in     = b;
        @(negedge clk);
        bus1.start_in = 1'b0;
        lat  = 0;
        held = 1'b1;
        while (!bus1.done_out && lat < 20) begin
            if (bus1.sum_out !== last_sum1 || bus1.carry_out !== last_c1) held = 1'b0;
            @(negedge clk);
            lat++;
        end
        check("lat1", lat, 1);
        check("hold1", held, 1'b1);
        check("sum1", bus1.sum_out, exp[0]);
        check("carry1", bus1.carry_out, exp[1]);
        last_sum1 = exp[0];
        last_c1   = exp[1];
        @(negedge clk);
        check("done1_single", bus1.done_out, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] expq[$];
        logic [8:0] want;
        int         dones;
        logic [7:0] ra;
        logic [7:0] rb;

        rst_n         = 1'b0;
        bus8.start_in = 1'b0;
        bus8.a_in     = '0;
        bus8.b_in     = '0;
        bus1.start_in = 1'b0;
        bus1.a_in     = '0;
        bus1.b_in     = '0;
        repeat (3) @(negedge clk);
        check("rst_busy8", bus8.busy_out, 1'b0);
        check("rst_done8", bus8.done_out, 1'b0);
        check("rst_sum8", bus8.sum_out, 8'h00);
        check("rst_carry8", bus8.carry_out, 1'b0);
        check("rst_busy1", bus1.busy_out, 1'b0);
        check("rst_sum1", bus1.sum_out, 1'b0);
        rst_n = 1'b1;

        // Directed corner values.
        op8(8'h5A, 8'h3C, 1'b0);
        op8(8'hFF, 8'h01, 1'b0);
        op8(8'hFF, 8'hFF, 1'b0);
        op8(8'h00, 8'h00, 1'b0);

        // Start held high: operands re-captured only in DONE cycles (every 9 edges).
        dones = 0;
        @(negedge clk);
        ra = 8'($urandom);
        rb = 8'($urandom);
        bus8.start_in = 1'b1;
        bus8.a_in     = ra;
        bus8.b_in     = rb;
        expq.push_back({1'b0, ra} + {1'b0, rb});
        for (int t = 1; t <= 27; t++) begin
            @(negedge clk);
            if (bus8.done_out) begin
                dones++;
                check("b2b_when", t % 9, 0);
                want = (expq.size() > 0) ? expq.pop_front() : 9'h1FF;
                check("b2b_result", {bus8.carry_out, bus8.sum_out}, want);
                last_sum8 = want[7:0];
                last_c8   = want[8];
            end
            if (t == 27) begin
                bus8.start_in = 1'b0;
            end else begin
                ra = 8'($urandom);
                rb = 8'($urandom);
                bus8.a_in = ra;
                bus8.b_in = rb;
                if (t % 9 == 0) expq.push_back({1'b0, ra} + {1'b0, rb});
            end
        end
        check("b2b_dones", dones, 3);
        @(negedge clk);
        check("b2b_done_drop", bus8.done_out, 1'b0);

        // Start pulses during RUN are ignored.
        op8(8'h33, 8'h44, 1'b1);

        // Reset in RUN cycle 4 aborts everything.
        @(negedge clk);
        bus8.start_in = 1'b1;
        bus8.a_in     = 8'hAB;
        bus8.b_in     = 8'hCD;
        @(negedge clk);
        bus8.start_in = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", bus8.busy_out, 1'b0);
        check("abort_done", bus8.done_out, 1'b0);
        check("abort_sum", bus8.sum_out, 8'h00);
        check("abort_carry", bus8.carry_out, 1'b0);
        @(negedge clk);
        check("abort_no_done", bus8.done_out, 1'b0);
        rst_n     = 1'b1;
        last_sum8 = '0;
        last_c8   = 1'b0;
        last_sum1 = 1'b0;
        last_c1   = 1'b0;
        op8(8'h01, 8'h02, 1'b0);

        // WIDTH=1 instance.
        op1(1'b1, 1'b1);
        for (int i = 0; i < 8; i++) op1(1'($urandom), 1'($urandom));

        // Random vectors.
        for (int i = 0; i < 1000; i++) op8(8'($urandom), 8'($urandom), 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
